// File: rtl/mcu_spi_dac_out_pkg.sv
// Shared types and constants for the MCU-to-DAC return path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcu_spi_dac_out_pkg;

  localparam int WORD_W  = 16;
  localparam int DAC_W   = 12;
  localparam int FRAME_W = 4 + DAC_W;
  localparam logic [3:0] DAC_CFG = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    LATCH
  } dac_state_t;

  // DAC serial frame: config header followed by the 12-bit code.
  function automatic logic [FRAME_W-1:0] dac_frame(input logic [3:0] cfg,
                                                   input logic [DAC_W-1:0] code);
    return {cfg, code};
  endfunction

endpackage

// File: rtl/mcu_spi_dac_out_if.sv
// Pin bundle between the MCU SPI link, the sample tick and the DAC.
// Latency: n/a (wires only).
// Backpressure: rx_ready tells the MCU whether another word fits.
interface mcu_spi_dac_out_if;

  logic mcu_sck;
  logic mcu_sdi;
  logic mcu_cs_n;
  logic start_sample;
  logic rx_ready;
  logic dac_cs_n;
  logic dac_sdi;
  logic dac_ldac_n;
  logic underrun;
  logic overrun;

  modport master (
    output mcu_sck, mcu_sdi, mcu_cs_n, start_sample,
    input  rx_ready, dac_cs_n, dac_sdi, dac_ldac_n, underrun, overrun
  );

  modport slave (
    input  mcu_sck, mcu_sdi, mcu_cs_n, start_sample,
    output rx_ready, dac_cs_n, dac_sdi, dac_ldac_n, underrun, overrun
  );

endinterface

// File: rtl/mcu_spi_dac_out_fifo.sv
// Small circular sample buffer with pointers mod DEPTH and an occupancy count.
// Latency: pushed word is readable on pop_dat the cycle after the push.
// Backpressure: push while full is only honoured together with a pop; pop while empty is ignored.
module sample_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int WORD_W = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_dat,
  input  logic              pop,
  output logic [WORD_W-1:0] pop_dat,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mcu_spi_dac_out.sv
// MCU SPI slave receiver feeding a sample FIFO that is played out to a 12-bit SPI DAC.
// Latency: completed MCU word reaches the DAC latch 18 clk after the next start_sample.
// Backpressure: rx_ready low when FIFO full; words arriving then are dropped and flag overrun.
module mcu_spi_dac_out #(
  parameter int         DEPTH   = 4,
  parameter int         WORD_W  = mcu_spi_dac_out_pkg::WORD_W,
  parameter logic [3:0] DAC_CFG = mcu_spi_dac_out_pkg::DAC_CFG
) (
  input logic               clk,
  input logic               reset,
  mcu_spi_dac_out_if.slave  io
);
  import mcu_spi_dac_out_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BIT_W = $clog2(WORD_W);
  localparam int FBIT_W = $clog2(FRAME_W);

  // ---------------- MCU receive side ----------------
  logic [1:0] sck_sync;
  logic [1:0] sdi_sync;
  logic [1:0] cs_sync;
  logic       sck_prev;
  logic       sck_rise;

  // Two-flop synchronizers on the asynchronous MCU pins, plus edge history for sck.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync <= 2'b00;
      sdi_sync <= 2'b00;
      cs_sync  <= 2'b11;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], io.mcu_sck};
      sdi_sync <= {sdi_sync[0], io.mcu_sdi};
      cs_sync  <= {cs_sync[0], io.mcu_cs_n};
      sck_prev <= sck_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] && !sck_prev;

  // Only the low DAC_W bits of each word are kept; the upper nibble of the MCU
  // word carries nothing the DAC uses, so it simply shifts out of the register.
  logic [DAC_W-2:0] rx_shift;
  logic [BIT_W-1:0] rx_cnt;
  logic             push_vld;
  logic [DAC_W-1:0] push_dat;

  // Bit shifter and counter; the 16th bit registers a push for the next clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shift <= '0;
      rx_cnt   <= '0;
      push_vld <= 1'b0;
      push_dat <= '0;
    end else begin
      push_vld <= 1'b0;
      if (cs_sync[1]) begin
        rx_cnt <= '0;
      end else if (sck_rise) begin
        rx_shift <= {rx_shift[DAC_W-3:0], sdi_sync[1]};
        if (rx_cnt == BIT_W'(WORD_W - 1)) begin
          push_vld <= 1'b1;
          push_dat <= {rx_shift, sdi_sync[1]};
          rx_cnt   <= '0;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- FIFO ----------------
  logic             fifo_pop;
  logic [DAC_W-1:0] fifo_dat;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  sample_fifo #(
    .DEPTH  (DEPTH),
    .WORD_W (DAC_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign io.rx_ready = (fifo_count != CNT_W'(DEPTH));

  logic overrun_q;

  // Sticky overrun: a completed word found no room and no pop freeing a slot.
  always_ff @(posedge clk) begin
    if (reset) overrun_q <= 1'b0;
    else if (push_vld && fifo_full && !fifo_pop) overrun_q <= 1'b1;
  end

  // ---------------- DAC side ----------------
  dac_state_t         state;
  logic [FBIT_W-1:0]  bit_cnt;
  logic [FRAME_W-1:0] frame_sr;
  logic [DAC_W-1:0]   last_sample;
  logic [DAC_W-1:0]   next_sample;
  logic [FRAME_W-1:0] next_frame;
  logic               dac_cs_n_q;
  logic               dac_sdi_q;
  logic               dac_ldac_n_q;
  logic               underrun_q;

  assign fifo_pop    = (state == IDLE) && io.start_sample && !fifo_empty;
  assign next_sample = fifo_empty ? last_sample : fifo_dat;
  assign next_frame  = dac_frame(DAC_CFG, next_sample);

  // DAC frame sequencer: load on tick, shift 16 bits, deselect, pulse LDAC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      frame_sr     <= '0;
      last_sample  <= {1'b1, {(DAC_W-1){1'b0}}};
      dac_cs_n_q   <= 1'b1;
      dac_sdi_q    <= 1'b0;
      dac_ldac_n_q <= 1'b1;
      underrun_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.start_sample) begin
            dac_sdi_q  <= next_frame[FRAME_W-1];
            frame_sr   <= {next_frame[FRAME_W-2:0], 1'b0};
            dac_cs_n_q <= 1'b0;
            bit_cnt    <= '0;
            state      <= SHIFT;
            if (fifo_empty) underrun_q  <= 1'b1;
            else            last_sample <= fifo_dat;
          end
        end
        SHIFT: begin
          if (bit_cnt == FBIT_W'(FRAME_W - 1)) begin
            dac_cs_n_q <= 1'b1;
            dac_sdi_q  <= 1'b0;
            state      <= GAP;
          end else begin
            dac_sdi_q <= frame_sr[FRAME_W-1];
            frame_sr  <= {frame_sr[FRAME_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        GAP: begin
          dac_ldac_n_q <= 1'b0;
          state        <= LATCH;
        end
        LATCH: begin
          dac_ldac_n_q <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.dac_cs_n   = dac_cs_n_q;
  assign io.dac_sdi    = dac_sdi_q;
  assign io.dac_ldac_n = dac_ldac_n_q;
  assign io.underrun   = underrun_q;
  assign io.overrun    = overrun_q;

endmodule

// File: tb/tb_mcu_spi_dac_out.sv
// Directed bench for the MCU-to-DAC return path with hand-computed frames.
// Latency: n/a.
// Backpressure: exercises full FIFO, overrun and simultaneous push/pop.
module tb_mcu_spi_dac_out;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mcu_spi_dac_out_if io ();

  mcu_spi_dac_out #(
    .DEPTH   (4),
    .WORD_W  (16),
    .DAC_CFG (4'b0111)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Sends the top nbits of w, MSB first, sck = clk/8; optionally closes the frame.
  task automatic mcu_send(input logic [15:0] w, input int nbits, input bit close);
    io.mcu_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      io.mcu_sdi = w[15-i];
      repeat (4) @(negedge clk);
      io.mcu_sck = 1'b1;
      repeat (4) @(negedge clk);
      io.mcu_sck = 1'b0;
    end
    if (close) begin
      repeat (4) @(negedge clk);
      io.mcu_cs_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  // Called with start_sample just raised at a negedge; samples the whole DAC frame.
  task automatic collect_frame(input logic [15:0] exp, input string tag);
    logic [15:0] fr;
    logic        cs_ok;
    fr    = '0;
    cs_ok = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      io.start_sample = 1'b0;
      fr[i] = io.dac_sdi;
      if (io.dac_cs_n !== 1'b0) cs_ok = 1'b0;
    end
    check({tag, " frame"}, 32'(fr), 32'(exp));
    check({tag, " cs_low_16"}, 32'(cs_ok), 32'd1);
    @(negedge clk);
    check({tag, " gap_cs_n"}, 32'(io.dac_cs_n), 32'd1);
    check({tag, " gap_ldac_n"}, 32'(io.dac_ldac_n), 32'd1);
    @(negedge clk);
    check({tag, " latch_ldac_n"}, 32'(io.dac_ldac_n), 32'd0);
    @(negedge clk);
    check({tag, " idle_ldac_n"}, 32'(io.dac_ldac_n), 32'd1);
  endtask

  task automatic dac_frame_check(input logic [15:0] exp, input string tag);
    @(negedge clk);
    io.start_sample = 1'b1;
    collect_frame(exp, tag);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    reset           = 1'b1;
    io.mcu_sck      = 1'b0;
    io.mcu_sdi      = 1'b0;
    io.mcu_cs_n     = 1'b1;
    io.start_sample = 1'b0;

    // Test 1: reset state, then underrun frame at mid-scale.
    do_reset();
    check("rst dac_cs_n",   32'(io.dac_cs_n),   32'd1);
    check("rst dac_ldac_n", 32'(io.dac_ldac_n), 32'd1);
    check("rst dac_sdi",    32'(io.dac_sdi),    32'd0);
    check("rst rx_ready",   32'(io.rx_ready),   32'd1);
    check("rst underrun",   32'(io.underrun),   32'd0);
    check("rst overrun",    32'(io.overrun),    32'd0);
    dac_frame_check(16'h7800, "t1");
    check("t1 underrun", 32'(io.underrun), 32'd1);

    // Test 2: single word round trip.
    do_reset();
    mcu_send(16'h0ABC, 16, 1'b1);
    check("t2 rx_ready", 32'(io.rx_ready), 32'd1);
    check("t2 count_pre", 32'(dut.u_fifo.count), 32'd1);
    dac_frame_check(16'h7ABC, "t2");
    check("t2 count_post", 32'(dut.u_fifo.count), 32'd0);
    check("t2 underrun", 32'(io.underrun), 32'd0);

    // Test 3: fill, overflow, drain in order.
    do_reset();
    for (int k = 1; k <= 4; k++) mcu_send(16'(k), 16, 1'b1);
    check("t3 rx_ready_full", 32'(io.rx_ready), 32'd0);
    check("t3 overrun_pre", 32'(io.overrun), 32'd0);
    mcu_send(16'h0005, 16, 1'b1);
    check("t3 overrun", 32'(io.overrun), 32'd1);
    check("t3 count_full", 32'(dut.u_fifo.count), 32'd4);
    dac_frame_check(16'h7001, "t3a");
    check("t3 rx_ready_after_pop", 32'(io.rx_ready), 32'd1);
    dac_frame_check(16'h7002, "t3b");
    dac_frame_check(16'h7003, "t3c");
    dac_frame_check(16'h7004, "t3d");
    check("t3 count_empty", 32'(dut.u_fifo.count), 32'd0);
    check("t3 underrun", 32'(io.underrun), 32'd0);

    // Test 4: aborted partial word is discarded.
    do_reset();
    mcu_send(16'hFFFF, 9, 1'b1);
    check("t4 count_partial", 32'(dut.u_fifo.count), 32'd0);
    mcu_send(16'h0123, 16, 1'b1);
    check("t4 count_one", 32'(dut.u_fifo.count), 32'd1);
    dac_frame_check(16'h7123, "t4");
    check("t4 count_post", 32'(dut.u_fifo.count), 32'd0);

    // Test 5: push into a full FIFO in the same clk as a pop.
    do_reset();
    for (int k = 1; k <= 4; k++) mcu_send(16'h0010 + 16'(k), 16, 1'b1);
    check("t5 count_full", 32'(dut.u_fifo.count), 32'd4);
    mcu_send(16'h0015, 15, 1'b0);
    io.mcu_sdi = 1'b1;
    repeat (4) @(negedge clk);
    io.mcu_sck = 1'b1;
    repeat (3) @(negedge clk);
    io.start_sample = 1'b1;
    collect_frame(16'h7011, "t5a");
    io.mcu_sck = 1'b0;
    check("t5 count_same", 32'(dut.u_fifo.count), 32'd4);
    check("t5 overrun", 32'(io.overrun), 32'd0);
    repeat (4) @(negedge clk);
    io.mcu_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    dac_frame_check(16'h7012, "t5b");
    dac_frame_check(16'h7013, "t5c");
    dac_frame_check(16'h7014, "t5d");
    dac_frame_check(16'h7015, "t5e");

    // Test 6: start_sample during SHIFT ignored; reset mid-frame aborts.
    do_reset();
    mcu_send(16'h0456, 16, 1'b1);
    mcu_send(16'h0789, 16, 1'b1);
    @(negedge clk);
    io.start_sample = 1'b1;
    @(negedge clk);
    io.start_sample = 1'b0;
    check("t6 count_after_pop", 32'(dut.u_fifo.count), 32'd1);
    repeat (3) @(negedge clk);
    io.start_sample = 1'b1;
    @(negedge clk);
    io.start_sample = 1'b0;
    check("t6 count_ignored", 32'(dut.u_fifo.count), 32'd1);
    check("t6 cs_still_low", 32'(io.dac_cs_n), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6 rst dac_cs_n", 32'(io.dac_cs_n), 32'd1);
    check("t6 rst ldac_n", 32'(io.dac_ldac_n), 32'd1);
    check("t6 rst count", 32'(dut.u_fifo.count), 32'd0);
    check("t6 rst rx_ready", 32'(io.rx_ready), 32'd1);
    repeat (2) @(negedge clk);
    dac_frame_check(16'h7800, "t6");
    check("t6 underrun", 32'(io.underrun), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
